// File: rtl/minterm_sweep_if.sv
// Handshake and result bundle between the minterm sweep controller and its user.
// The slave side is the controller; the master side drives start/abort and returns f_in.
interface minterm_sweep_if;
  logic        start;
  logic        abort;
  logic        f_in;
  logic        a;
  logic        b;
  logic        c;
  logic        d;
  logic        busy;
  logic        done;
  logic [15:0] map;
  logic [4:0]  err_count;
  logic        match;

  modport master (
    output start, abort, f_in,
    input  a, b, c, d, busy, done, map, err_count, match
  );

  modport slave (
    input  start, abort, f_in,
    output a, b, c, d, busy, done, map, err_count, match
  );
endinterface

// File: rtl/minterm_sweep_ctrl.sv
// Sweeps all 16 input vectors of a 4-input function, waits SETTLE+1 cycles per vector,
// samples F into a truth-table map and compares it against the golden minterm map.
module minterm_sweep_ctrl #(
  parameter int          SETTLE   = 2,
  parameter logic [15:0] EXPECTED = 16'h88B7
) (
  input logic           clk,
  input logic           rst_n,
  minterm_sweep_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, DONE} state_t;

  localparam logic [3:0] SETTLE_L = 4'(SETTLE);

  state_t      state;
  logic [3:0]  idx;
  logic [3:0]  cnt;
  logic [15:0] map_q;
  logic [4:0]  err_q;
  logic [15:0] map_capt;

  // Error count saturates at 16 so it can never wrap.
  function automatic logic [4:0] sat_inc(input logic [4:0] v);
    return (v >= 5'd16) ? 5'd16 : v + 5'd1;
  endfunction

  always_comb begin
    map_capt      = map_q;
    map_capt[idx] = bus.f_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= 4'd0;
      cnt       <= 4'd0;
      map_q     <= 16'h0000;
      err_q     <= 5'd0;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
      bus.match <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            idx       <= 4'd0;
            map_q     <= 16'h0000;
            err_q     <= 5'd0;
            bus.match <= 1'b0;
            cnt       <= SETTLE_L;
            bus.busy  <= 1'b1;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (bus.abort) begin
            idx       <= 4'd0;
            bus.match <= 1'b0;
            bus.busy  <= 1'b0;
            state     <= IDLE;
          end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state <= SAMPLE;
          end
        end
        SAMPLE: begin
          // Abort takes priority: the pending capture is dropped.
          if (bus.abort) begin
            idx       <= 4'd0;
            bus.match <= 1'b0;
            bus.busy  <= 1'b0;
            state     <= IDLE;
          end else begin
            map_q <= map_capt;
            if (bus.f_in != EXPECTED[idx]) err_q <= sat_inc(err_q);
            if (idx == 4'd15) begin
              bus.match <= (map_capt == EXPECTED);
              bus.busy  <= 1'b0;
              bus.done  <= 1'b1;
              state     <= DONE;
            end else begin
              idx   <= idx + 4'd1;
              cnt   <= SETTLE_L;
              state <= WAIT;
            end
          end
        end
        DONE: begin
          idx   <= 4'd0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign {bus.a, bus.b, bus.c, bus.d} = idx;
  assign bus.map       = map_q;
  assign bus.err_count = err_q;

endmodule
